// File: rtl/caliptra_fpga_axil_regbank_if.sv
// rtl/caliptra_fpga_axil_regbank_if.sv - AXI4-Lite bundle between the FPGA interconnect and the register bank
interface caliptra_fpga_axil_regbank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arprot, rready,
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arready, rvalid, rdata, rresp,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arprot, rready,
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arready, rvalid, rdata, rresp,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/caliptra_fpga_axil_regbank.sv
// rtl/caliptra_fpga_axil_regbank.sv - parametrised AXI4-Lite register bank with RO slots, byte strobes and SLVERR
module caliptra_fpga_axil_regbank #(
    parameter int                  DATA_W   = 64,
    parameter int                  NUM_REGS = 16,
    parameter int                  ADDR_W   = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         aclk,
    input  logic                         rst,
    caliptra_fpga_axil_regbank_if.slave  axi,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);
    localparam int B      = $clog2(DATA_W / 8);
    localparam int K      = $clog2(NUM_REGS);
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              aw_held_q, w_held_q;
    logic [K-1:0]      aw_idx_q;
    logic              aw_err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NBYTES-1:0] wstrb_q;
    logic              bvalid_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [NUM_REGS-1:0] pulse_q;

    logic              aw_fire, w_fire, ar_fire, commit;
    logic [K-1:0]      aw_idx_d, ar_idx;
    logic              aw_err_d, ar_oor;
    logic [DATA_W-1:0] merged_d, rdata_d;
    logic [1:0]        rresp_d;

    assign axi.awready  = !rst && !aw_held_q && !bvalid_q;
    assign axi.wready   = !rst && !w_held_q && !bvalid_q;
    assign axi.arready  = !rst && !rvalid_q;
    assign axi.bvalid   = bvalid_q;
    assign axi.bresp    = bresp_q;
    assign axi.rvalid   = rvalid_q;
    assign axi.rresp    = rresp_q;
    assign axi.rdata    = rdata_q;
    assign reg_wr_pulse = pulse_q;

    assign aw_fire = axi.awvalid && axi.awready;
    assign w_fire  = axi.wvalid && axi.wready;
    assign ar_fire = axi.arvalid && axi.arready;
    assign commit  = aw_held_q && w_held_q;

    logic unused_ok;
    assign unused_ok = ^{axi.arprot, axi.awprot, axi.araddr[B-1:0], axi.awaddr[B-1:0]};

    // Decode happens at AW acceptance so only index and error flag are held.
    always_comb begin
        aw_idx_d = axi.awaddr[B +: K];
        aw_err_d = ((axi.awaddr >> (B + K)) != '0) || RO_MASK[aw_idx_d];
        ar_idx   = axi.araddr[B +: K];
        ar_oor   = (axi.araddr >> (B + K)) != '0;
        rdata_d  = '0;
        rresp_d  = 2'b00;
        if (ar_oor) begin
            rresp_d = 2'b10;
        end else if (RO_MASK[ar_idx]) begin
            rdata_d = reg_in[ar_idx*DATA_W +: DATA_W];
        end else begin
            rdata_d = regs_q[ar_idx];
        end
    end

    always_comb begin
        merged_d = regs_q[aw_idx_q];
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_q[b]) merged_d[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            aw_err_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            pulse_q   <= '0;
        end else begin
            pulse_q <= '0;
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                aw_idx_q  <= aw_idx_d;
                aw_err_q  <= aw_err_d;
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                wdata_q  <= axi.wdata;
                wstrb_q  <= axi.wstrb;
            end
            // Holds cannot both be valid while bvalid is up, so commit and B handshake never overlap.
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= aw_err_q ? 2'b10 : 2'b00;
                if (!aw_err_q && (wstrb_q != '0)) begin
                    regs_q[aw_idx_q]  <= merged_d;
                    pulse_q[aw_idx_q] <= 1'b1;
                end
            end else if (bvalid_q && axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rvalid_q && axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_caliptra_fpga_axil_regbank.sv
// tb/tb_caliptra_fpga_axil_regbank.sv - directed self-checking bench for the AXI4-Lite register bank
module tb_caliptra_fpga_axil_regbank;
    logic          aclk = 1'b0;
    logic          rst  = 1'b1;
    logic [1023:0] reg_out;
    logic [1023:0] reg_in = '0;
    logic [15:0]   reg_wr_pulse;
    int            tests = 0;
    int            fails = 0;

    caliptra_fpga_axil_regbank_if #(.ADDR_W(32), .DATA_W(64)) axi();

    caliptra_fpga_axil_regbank #(
        .DATA_W(64), .NUM_REGS(16), .ADDR_W(32), .RO_MASK(16'h0008)
    ) dut (
        .aclk(aclk), .rst(rst), .axi(axi),
        .reg_out(reg_out), .reg_in(reg_in), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] slot(input int i);
        return reg_out[i*64 +: 64];
    endfunction

    // Drives AW and W together, returns cycles from commit to bvalid and pulses seen up to bvalid.
    task automatic wr_issue(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output int lat, output int pulses);
        bit aw_go, w_go, aw_done, w_done;
        int n;
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = axi.awvalid && axi.awready;
            w_go  = axi.wvalid && axi.wready;
            @(posedge aclk); #1;
            if (aw_go) begin axi.awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin axi.wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        pulses = $countones(reg_wr_pulse);
        lat = 0;
        while (!axi.bvalid && lat < 20) begin
            @(posedge aclk); #1;
            lat++;
            pulses += $countones(reg_wr_pulse);
        end
    endtask

    task automatic b_accept(output int pulses_after);
        axi.bready = 1'b1;
        @(posedge aclk); #1;
        axi.bready = 1'b0;
        pulses_after = $countones(reg_wr_pulse);
    endtask

    task automatic rd_issue(input logic [31:0] a, output int lat);
        int n;
        axi.araddr = a; axi.arvalid = 1'b1; n = 0;
        while (!axi.arready && n < 20) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        axi.arvalid = 1'b0;
        lat = 0;
        while (!axi.rvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
    endtask

    task automatic r_accept();
        axi.rready = 1'b1;
        @(posedge aclk); #1;
        axi.rready = 1'b0;
    endtask

    initial begin
        int lat, pulses, pa;
        logic [63:0] held_rdata;
        axi.arvalid = 0; axi.araddr = '0; axi.arprot = '0; axi.rready = 0;
        axi.awvalid = 0; axi.awaddr = '0; axi.awprot = '0;
        axi.wvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.bready = 0;
        reg_in[3*64 +: 64] = 64'h0000_0000_0000_CAFE;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", 64'(axi.awready), 64'd0);
        chk("rst_arready", 64'(axi.arready), 64'd0);
        chk("rst_bvalid", 64'(axi.bvalid), 64'd0);
        chk("rst_regout", 64'(|reg_out), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_wready", 64'(axi.wready), 64'd1);
        chk("post_rst_arready", 64'(axi.arready), 64'd1);
        @(posedge aclk); #1;

        wr_issue(32'h08, 64'hDEADBEEF_01234567, 8'hFF, lat, pulses);
        chk("w1_latency", 64'(lat), 64'd1);
        chk("w1_bresp", 64'(axi.bresp), 64'd0);
        chk("w1_reg1", slot(1), 64'hDEADBEEF_01234567);
        chk("w1_pulse1", 64'(reg_wr_pulse), 64'h0002);
        b_accept(pa);
        chk("w1_pulse_once", 64'(pulses + pa), 64'd1);
        chk("w1_awready_back", 64'(axi.awready), 64'd1);
        rd_issue(32'h08, lat);
        chk("r1_latency", 64'(lat), 64'd0);
        chk("r1_rdata", axi.rdata, 64'hDEADBEEF_01234567);
        chk("r1_rresp", 64'(axi.rresp), 64'd0);
        r_accept();
        chk("r1_arready_back", 64'(axi.arready), 64'd1);

        wr_issue(32'h10, 64'h1111_2222_3333_4444, 8'hFF, lat, pulses);
        b_accept(pa);
        axi.wdata = 64'hFFFF_FFFF_AABB_CCDD; axi.wstrb = 8'h0F; axi.wvalid = 1'b1;
        chk("w2_wready", 64'(axi.wready), 64'd1);
        @(posedge aclk); #1;
        axi.wvalid = 1'b0;
        chk("w2_wready_held", 64'(axi.wready), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        axi.awaddr = 32'h10; axi.awvalid = 1'b1;
        chk("w2_awready", 64'(axi.awready), 64'd1);
        @(posedge aclk); #1;
        axi.awvalid = 1'b0;
        chk("w2_commit_no_bvalid", 64'(axi.bvalid), 64'd0);
        @(posedge aclk); #1;
        chk("w2_bvalid", 64'(axi.bvalid), 64'd1);
        chk("w2_bresp", 64'(axi.bresp), 64'd0);
        chk("w2_reg2", slot(2), 64'h1111_2222_AABB_CCDD);
        chk("w2_pulse2", 64'(reg_wr_pulse), 64'h0004);
        b_accept(pa);

        wr_issue(32'h08, 64'h0, 8'h00, lat, pulses);
        chk("wz_bresp", 64'(axi.bresp), 64'd0);
        b_accept(pa);
        chk("wz_no_pulse", 64'(pulses + pa), 64'd0);
        chk("wz_reg1_kept", slot(1), 64'hDEADBEEF_01234567);

        wr_issue(32'h80, 64'h1234, 8'hFF, lat, pulses);
        chk("oor_bresp", 64'(axi.bresp), 64'd2);
        b_accept(pa);
        chk("oor_no_pulse", 64'(pulses + pa), 64'd0);
        chk("oor_reg0", slot(0), 64'd0);
        rd_issue(32'h80, lat);
        chk("oor_rdata", axi.rdata, 64'd0);
        chk("oor_rresp", 64'(axi.rresp), 64'd2);
        r_accept();

        wr_issue(32'h18, 64'h5555, 8'hFF, lat, pulses);
        chk("ro_bresp", 64'(axi.bresp), 64'd2);
        b_accept(pa);
        chk("ro_no_pulse", 64'(pulses + pa), 64'd0);
        chk("ro_regout3", slot(3), 64'd0);
        rd_issue(32'h18, lat);
        chk("ro_rdata", axi.rdata, 64'h0000_0000_0000_CAFE);
        chk("ro_rresp", 64'(axi.rresp), 64'd0);
        r_accept();

        wr_issue(32'h28, 64'hA5A5_0000_0000_5A5A, 8'hFF, lat, pulses);
        for (int i = 0; i < 5; i++) begin
            chk("stall_bvalid", 64'(axi.bvalid), 64'd1);
            chk("stall_bresp", 64'(axi.bresp), 64'd0);
            chk("stall_awready", 64'(axi.awready), 64'd0);
            chk("stall_wready", 64'(axi.wready), 64'd0);
            @(posedge aclk); #1;
        end
        b_accept(pa);
        rd_issue(32'h28, lat);
        held_rdata = axi.rdata;
        chk("stall_rdata_val", held_rdata, 64'hA5A5_0000_0000_5A5A);
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            chk("stall_rdata", axi.rdata, 64'hA5A5_0000_0000_5A5A);
            chk("stall_arready", 64'(axi.arready), 64'd0);
        end
        r_accept();

        wr_issue(32'h20, 64'h77, 8'hFF, lat, pulses);
        rd_issue(32'h20, lat);
        axi.araddr = 32'h08; axi.arvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_bvalid", 64'(axi.bvalid), 64'd0);
        chk("mid_rst_rvalid", 64'(axi.rvalid), 64'd0);
        chk("mid_rst_regs", 64'(|reg_out), 64'd0);
        chk("mid_rst_arready", 64'(axi.arready), 64'd0);
        axi.arvalid = 1'b0;
        @(posedge aclk); #1;
        rst = 1'b0;
        @(posedge aclk); #1;
        wr_issue(32'h00, 64'hFEED, 8'hFF, lat, pulses);
        chk("post_rst_bresp", 64'(axi.bresp), 64'd0);
        chk("post_rst_reg0", slot(0), 64'hFEED);
        b_accept(pa);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
